ifu_align: RTL

IFU_ALIGN -- requirements
Module: ifu_align

---
 rtl/ifu_align.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ifu_align.sv
// Instruction fetch aligner: turns a word-wide fetch stream into halfword-aligned
// instruction windows for a mixed 16/32-bit instruction set, with redirect and drop handling.
module ifu_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:2] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    input  logic        redirect,
    input  logic [31:1] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_win,
    output logic [31:1] instr_pc,
    input  logic        compressed
);

    logic [15:0] fifo_q [4];
    logic [15:0] shifted [4];
    logic [15:0] fifo_d [4];
    logic [2:0]  count_q;
    logic [2:0]  count_pop;
    logic [2:0]  count_d;
    logic        drop_q;
    logic        skip_lo_q;
    logic        started_q;
    logic [31:2] addr_q;
    logic [31:2] next_addr_q;
    logic [31:1] pc_q;
    logic        accept;
    logic        do_push;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [1:0]  slot;
    logic [1:0]  slot_hi;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high
    // at the rising edge; the producer holds its payload stable until then.
    // fetch_req/fetch_addr form the valid/payload of the fetch port, fetch_ack is its ready.
    assign fetch_req  = started_q && (count_q <= 3'd2);
    assign fetch_addr = addr_q;
    assign instr_pc   = pc_q;

    assign instr_win = (count_q >= 3'd2) ? {fifo_q[1], fifo_q[0]} :
                       (count_q == 3'd1) ? {16'h0000, fifo_q[0]}  : 32'h0000_0000;

    assign instr_valid = !redirect &&
                         ((count_q >= 3'd2) || ((count_q == 3'd1) && (fifo_q[0][1:0] != 2'b11)));

    assign accept = instr_valid && instr_ready;
    // Never pop more than is held, even if the decompressor disagrees with the FIFO.
    assign pop_n  = !accept ? 2'd0 : ((compressed || (count_q == 3'd1)) ? 2'd1 : 2'd2);

    assign do_push = fetch_req && fetch_ack && !redirect && !drop_q;
    assign push_n  = !do_push ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);

    assign count_pop = count_q - {1'b0, pop_n};
    assign count_d   = count_pop + {1'b0, push_n};
    assign slot      = count_pop[1:0];
    assign slot_hi   = slot + 2'd1;

    always_comb begin
        shifted = fifo_q;
        case (pop_n)
            2'd1: begin
                shifted[0] = fifo_q[1];
                shifted[1] = fifo_q[2];
                shifted[2] = fifo_q[3];
                shifted[3] = 16'h0000;
            end
            2'd2: begin
                shifted[0] = fifo_q[2];
                shifted[1] = fifo_q[3];
                shifted[2] = 16'h0000;
                shifted[3] = 16'h0000;
            end
            default: ;
        endcase
        fifo_d = shifted;
        // Pop is applied first, so the push lands right after the surviving entries.
        if (push_n == 2'd2) begin
            fifo_d[slot]    = fetch_data[15:0];
            fifo_d[slot_hi] = fetch_data[31:16];
        end else if (push_n == 2'd1) begin
            fifo_d[slot] = fetch_data[31:16];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 16'h0000;
            count_q     <= 3'd0;
            drop_q      <= 1'b0;
            skip_lo_q   <= RESET_PC[1];
            started_q   <= 1'b0;
            addr_q      <= RESET_PC[31:2];
            next_addr_q <= RESET_PC[31:2];
            pc_q        <= RESET_PC[31:1];
        end else begin
            started_q <= 1'b1;
            if (redirect) begin
                count_q   <= 3'd0;
                pc_q      <= redirect_pc;
                skip_lo_q <= redirect_pc[1];
                // An unanswered request must finish at its old address; park the new one.
                if (fetch_req && !fetch_ack) begin
                    drop_q      <= 1'b1;
                    next_addr_q <= redirect_pc[31:2];
                end else begin
                    drop_q <= 1'b0;
                    addr_q <= redirect_pc[31:2];
                end
            end else begin
                fifo_q  <= fifo_d;
                count_q <= count_d;
                if (accept) pc_q <= pc_q + {29'd0, pop_n};
                if (fetch_req && fetch_ack) begin
                    if (drop_q) begin
                        drop_q <= 1'b0;
                        addr_q <= next_addr_q;
                    end else begin
                        skip_lo_q <= 1'b0;
                        addr_q    <= addr_q + 30'd1;
                    end
                end
            end
        end
    end

endmodule
